// File: rtl/entrada_captura.sv
// Debounced capture of a 16-bit switch word on a push-button, handed to a stalled processor.
// Optional macro ENTRADA_DEBOUNCE_EN enables the stability counter; without it capture is immediate.
module entrada_captura #(
    parameter int unsigned DEBOUNCE_CICLOS = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_entrada,
    input  logic        i_confirma_bt,
    input  logic        i_ler_da_entrada,
    input  logic        i_consumido,
    output logic [31:0] o_entrada_lida,
    output logic        o_dado_valido,
    output logic        o_confirma_pulso,
    output logic [2:0]  o_estado
);

    typedef enum logic [2:0] {
        StOcioso   = 3'd0,
        StEsperaBt = 3'd1,
        StEstavel  = 3'd2,
        StEntrega  = 3'd3,
        StSolta    = 3'd4
    } estado_t;

    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CICLOS)) begin : g_cnt_w_check
        $error("CNT_W too narrow for DEBOUNCE_CICLOS");
    end

    logic        r_bt_m, r_bt_s, r_bt_ant;
    logic [15:0] r_ent_m, r_ent_s;
    estado_t     r_estado, w_estado_prox;
    logic        r_em_entrega;
    logic [31:0] r_entrada_lida;
    logic        w_captura;
    logic        w_solta_fim;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bt_m   <= 1'b0;
            r_bt_s   <= 1'b0;
            r_bt_ant <= 1'b0;
            r_ent_m  <= '0;
            r_ent_s  <= '0;
        end else begin
            r_bt_m   <= i_confirma_bt;
            r_bt_s   <= r_bt_m;
            r_bt_ant <= r_bt_s;
            r_ent_m  <= i_entrada;
            r_ent_s  <= r_ent_m;
        end
    end

`ifdef ENTRADA_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CntFim = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_fim;

    assign w_cnt_fim   = (r_cnt == CntFim);
    assign w_captura   = (r_estado == StEstavel) && i_ler_da_entrada && r_bt_s && w_cnt_fim;
    assign w_solta_fim = !r_bt_s && w_cnt_fim;

    // Cleared on every state change, so each state starts counting from zero.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_estado_prox != r_estado) begin
            r_cnt <= '0;
        end else if ((r_estado == StEstavel && r_bt_s) || (r_estado == StSolta && !r_bt_s)) begin
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end
`else
    assign w_captura   = (r_estado == StEstavel) && i_ler_da_entrada;
    assign w_solta_fim = !r_bt_s;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado     <= StOcioso;
            r_em_entrega <= 1'b0;
        end else begin
            r_estado     <= w_estado_prox;
            r_em_entrega <= (r_estado == StEntrega);
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            StOcioso: begin
                if (i_ler_da_entrada) w_estado_prox = StEsperaBt;
            end
            StEsperaBt: begin
                if (!i_ler_da_entrada)         w_estado_prox = StOcioso;
                else if (r_bt_s && !r_bt_ant)  w_estado_prox = StEstavel;
            end
            StEstavel: begin
                if (!i_ler_da_entrada) w_estado_prox = StOcioso;
                else if (w_captura)    w_estado_prox = StEntrega;
                else if (!r_bt_s)      w_estado_prox = StEsperaBt;
            end
            StEntrega: begin
                if (i_consumido || !i_ler_da_entrada) w_estado_prox = StSolta;
            end
            StSolta: begin
                if (w_solta_fim) w_estado_prox = StOcioso;
            end
            default: w_estado_prox = StOcioso;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_entrada_lida <= '0;
        end else if (w_captura) begin
            r_entrada_lida <= {{16{r_ent_s[15]}}, r_ent_s};
        end
    end

    always_comb begin
        o_dado_valido    = (r_estado == StEntrega);
        o_confirma_pulso = (r_estado == StEntrega) && !r_em_entrega;
        o_estado         = r_estado;
        o_entrada_lida   = r_entrada_lida;
    end

endmodule

// File: tb/tb_entrada_captura.sv
// Scoreboard bench for entrada_captura: random switch words, bounces and handshakes.
// Expected capture value and arrival cycle are queued at the press; a monitor pops on each strobe.
module tb_entrada_captura;

    localparam int unsigned D = 4;
`ifdef ENTRADA_DEBOUNCE_EN
    localparam int Lat = 2 + D;
    localparam int Dm  = D;
    localparam bit DebEn = 1'b1;
`else
    localparam int Lat = 3;
    localparam int Dm  = 1;
    localparam bit DebEn = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_entrada = '0;
    logic        i_confirma_bt = 1'b0;
    logic        i_ler_da_entrada = 1'b0;
    logic        i_consumido = 1'b0;
    logic [31:0] o_entrada_lida;
    logic        o_dado_valido;
    logic        o_confirma_pulso;
    logic [2:0]  o_estado;

    entrada_captura #(
        .DEBOUNCE_CICLOS(D),
        .CNT_W          (4)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_entrada       (i_entrada),
        .i_confirma_bt   (i_confirma_bt),
        .i_ler_da_entrada(i_ler_da_entrada),
        .i_consumido     (i_consumido),
        .o_entrada_lida  (o_entrada_lida),
        .o_dado_valido   (o_dado_valido),
        .o_confirma_pulso(o_confirma_pulso),
        .o_estado        (o_estado)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] lida_esp = '0;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nome, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest queued capture, in value and in cycle.
    logic prev_dv = 1'b0;
    always @(negedge i_clock) begin
        exp_t e;
        if (i_reset) begin
            prev_dv <= 1'b0;
        end else begin
            if (o_confirma_pulso) begin
                chk("fila_sb", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("valor_capturado", o_entrada_lida, e.val);
                    chk("latencia", cyc, e.cyc);
                end
            end
            if (o_dado_valido && !prev_dv) chk("pulso_na_subida", {31'd0, o_confirma_pulso}, 1);
            if (o_dado_valido) chk("estado_entrega", {29'd0, o_estado}, 3);
            prev_dv <= o_dado_valido;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic salta(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            i_confirma_bt = pat[i];
            tick(1);
        end
        i_confirma_bt = 1'b0;
        tick(1);
    endtask

    // Random bounce whose high runs never last long enough to be accepted.
    task automatic salta_rand();
        logic [15:0] pat;
        int          n;
        int          run;
        pat = '0;
        run = 0;
        n   = int'($urandom_range(4, 12));
        for (int i = 0; i < n; i++) begin
            pat[i] = 1'($urandom);
            if (run >= int'(D) || i == n - 1) pat[i] = 1'b0;
            run = pat[i] ? run + 1 : 0;
        end
        salta(pat, n);
    endtask

    task automatic pressiona(input logic [15:0] v, input bit glitch);
        exp_t e;
        e.val    = 32'($signed(v));
        e.cyc    = cyc + 1 + Lat;
        lida_esp = e.val;
        sb.push_back(e);
        i_confirma_bt = 1'b1;
        if (glitch) begin
            tick(1);
            i_confirma_bt = 1'b0;
        end
        for (int i = 0; i < Lat + 20; i++) begin
            if (o_dado_valido) break;
            @(negedge i_clock);
        end
        chk("dv_sobe", {31'd0, o_dado_valido}, 1);
        @(posedge i_clock);
        #1;
    endtask

    task automatic consome(input bit via_consumido);
        i_entrada = 16'($urandom);
        tick(int'($urandom_range(1, 3)));
        chk("dv_mantido", {31'd0, o_dado_valido}, 1);
        chk("lida_estavel", o_entrada_lida, lida_esp);
        if (via_consumido) i_consumido = 1'b1;
        else i_ler_da_entrada = 1'b0;
        tick(1);
        i_consumido      = 1'b0;
        i_ler_da_entrada = 1'b0;
        chk("dv_cai", {31'd0, o_dado_valido}, 0);
        i_confirma_bt = 1'b0;
        tick(Dm + 6);
        chk("estado_ocioso", {29'd0, o_estado}, 0);
        chk("lida_apos_solta", o_entrada_lida, lida_esp);
    endtask

    // modo: 0 clean press, 1 fixed bounce 1,0,1,1,0, 2 random bounce (glitch press without debounce)
    task automatic transacao(input logic [15:0] v, input int modo, input bit via_consumido);
        i_entrada        = v;
        i_ler_da_entrada = 1'b1;
        tick(3);
        if (DebEn && modo == 1) salta(16'b01101, 5);
        if (DebEn && modo == 2) salta_rand();
        pressiona(v, !DebEn && modo != 0);
        consome(via_consumido);
    endtask

    initial begin
        logic [15:0] v;
        tick(3);
        chk("reset_dv", {31'd0, o_dado_valido}, 0);
        chk("reset_pulso", {31'd0, o_confirma_pulso}, 0);
        chk("reset_lida", o_entrada_lida, 0);
        chk("reset_estado", {29'd0, o_estado}, 0);
        i_reset = 1'b0;
        tick(2);

        transacao(16'h00A5, 0, 1'b1);
        transacao(16'h8001, 0, 1'b1);
        transacao(16'h1234, 1, 1'b1);

        // Button held before the request: nothing until release and a fresh press.
        i_confirma_bt = 1'b1;
        tick(6);
        i_ler_da_entrada = 1'b1;
        tick(Lat + 8);
        chk("segurado_sem_dv", {31'd0, o_dado_valido}, 0);
        chk("segurado_estado", {29'd0, o_estado}, 1);
        i_confirma_bt = 1'b0;
        v = 16'($urandom);
        i_entrada = v;
        tick(3);
        pressiona(v, 1'b0);
        consome(1'b1);

        // Request withdrawn before capture.
        i_entrada        = 16'($urandom);
        i_ler_da_entrada = 1'b1;
        tick(3);
        if (DebEn) begin
            i_confirma_bt = 1'b1;
            tick(4);
            chk("aborta_em_estavel", {29'd0, o_estado}, 2);
        end else begin
            chk("aborta_em_espera", {29'd0, o_estado}, 1);
        end
        i_ler_da_entrada = 1'b0;
        tick(1);
        chk("aborta_estado", {29'd0, o_estado}, 0);
        chk("aborta_lida", o_entrada_lida, lida_esp);
        i_confirma_bt = 1'b0;
        tick(Dm + 6);
        chk("aborta_sem_dv", {31'd0, o_dado_valido}, 0);

        // Reset while the word is being offered.
        v = 16'($urandom);
        i_entrada        = v;
        i_ler_da_entrada = 1'b1;
        tick(3);
        pressiona(v, 1'b0);
        @(posedge i_clock);
        #3;
        i_reset          = 1'b1;
        i_confirma_bt    = 1'b0;
        i_ler_da_entrada = 1'b0;
        #1;
        chk("rst_entrega_dv", {31'd0, o_dado_valido}, 0);
        chk("rst_entrega_pulso", {31'd0, o_confirma_pulso}, 0);
        chk("rst_entrega_lida", o_entrada_lida, 0);
        chk("rst_entrega_estado", {29'd0, o_estado}, 0);
        lida_esp = '0;
        tick(2);
        i_reset = 1'b0;
        tick(Lat + 8);
        chk("pos_reset_dv", {31'd0, o_dado_valido}, 0);
        chk("pos_reset_lida", o_entrada_lida, 0);

        for (int t = 0; t < 10; t++) begin
            transacao(16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        tick(4);
        chk("sb_vazio", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/entrada_captura.md
ENTRADA_CAPTURA -- requirements
Module: entrada_captura

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CICLOS, default 50000, the number of consecutive stable cycles needed to accept a button level.
REQ-002 The block SHALL have parameter CNT_W, default 16, the debounce counter width; 2^CNT_W > DEBOUNCE_CICLOS.
REQ-003 Port clock  in  1  free-running FPGA clock.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port entrada  in  16  raw switch word, asynchronous.
REQ-006 Port confirma_bt  in  1  raw push-button, active-high, asynchronous, bouncing.
REQ-007 Port ler_da_entrada  in  1  processor request: high while an input instruction is stalled.
REQ-008 Port consumido  in  1  processor acknowledge: high for at least one clock once the value is written back.
REQ-009 Port entrada_lida  out  32  captured switch word, sign-extended from bit 15.
REQ-010 Port dado_valido  out  1  high while entrada_lida is offered and not yet consumed.
REQ-011 Port confirma_pulso  out  1  single-cycle strobe on the cycle dado_valido rises.
REQ-012 Port estado  out  3  current FSM state encoding, for debug.

Function
REQ-013 confirma_bt and entrada SHALL each pass through a two-flop synchronizer; all logic below SHALL use the synchronized values (bt_s, ent_s).
REQ-014 FSM states SHALL be OCIOSO=0, ESPERA_BT=1, ESTAVEL=2, ENTREGA=3, SOLTA=4; other codes SHALL return to OCIOSO on the next cycle.
REQ-015 OCIOSO: on ler_da_entrada=1, the FSM SHALL go to ESPERA_BT; button activity in OCIOSO SHALL be ignored.
REQ-016 ESPERA_BT: the FSM SHALL advance to ESTAVEL only on a bt_s 0->1 edge; a button already held on entry SHALL be released first.
REQ-017 ESTAVEL: the counter SHALL clear on entry and increment each cycle while bt_s=1; bt_s=0 SHALL return the FSM to ESPERA_BT.
REQ-018 When the counter reaches DEBOUNCE_CICLOS-1 with bt_s=1, the block SHALL load entrada_lida from ent_s on that cycle and enter ENTREGA.
REQ-019 ler_da_entrada=0 in ESPERA_BT or ESTAVEL SHALL abort to OCIOSO without loading entrada_lida.
REQ-020 ENTREGA: dado_valido SHALL be 1; confirma_pulso SHALL be 1 only on the first ENTREGA cycle.
REQ-021 ENTREGA: consumido=1 or ler_da_entrada=0 SHALL move the FSM to SOLTA; dado_valido SHALL drop the following cycle.
REQ-022 SOLTA: the counter SHALL count consecutive bt_s=0 cycles; at DEBOUNCE_CICLOS-1 the FSM SHALL go to OCIOSO; any bt_s=1 SHALL clear the counter.
REQ-023 entrada_lida SHALL hold its last captured value in every state except the capture cycle.
REQ-024 Switch changes after capture SHALL NOT alter entrada_lida until the next capture.
REQ-025 Counter arithmetic SHALL saturate and never wrap.
REQ-026 Latency from the raw button rising edge to dado_valido=1 SHALL be exactly 2+DEBOUNCE_CICLOS cycles for a clean press.

Reset
REQ-027 reset=1 SHALL asynchronously force state to OCIOSO, counter to 0, entrada_lida to 0, dado_valido to 0, confirma_pulso to 0, and synchronizer flops to 0.
REQ-028 Reset during ENTREGA SHALL drop dado_valido immediately; no pulse SHALL be issued on reset release.

Configuration
REQ-029 With macro ENTRADA_DEBOUNCE_EN defined, the block SHALL behave as REQ-017 to REQ-022.
REQ-030 Without ENTRADA_DEBOUNCE_EN, ESTAVEL SHALL capture on its first cycle and SOLTA SHALL exit on the first bt_s=0 sample; the counter SHALL not be synthesized; latency SHALL be 3 cycles.

Verification (DEBOUNCE_CICLOS=4, ENTRADA_DEBOUNCE_EN defined unless stated)
REQ-031 Scenario: ler_da_entrada=1, entrada=16'h00A5, clean press -> dado_valido=1 at cycle 6 after the press, entrada_lida=32'h000000A5, one confirma_pulso.
REQ-032 Scenario: entrada=16'h8001, press, consumido pulse -> entrada_lida=32'hFFFF8001; dado_valido=0 one cycle after consumido.
REQ-033 Scenario: bounce 1,0,1,1,0 then a stable press -> no capture during the bounce; exactly one capture after 4 stable cycles.
REQ-034 Scenario: button held before ler_da_entrada rises -> no capture until release then press; ler_da_entrada dropped mid-ESTAVEL -> OCIOSO, entrada_lida unchanged.
REQ-035 Scenario: reset asserted in ENTREGA -> all outputs 0 immediately; estado=0.
REQ-036 Scenario: ENTRADA_DEBOUNCE_EN undefined, clean press -> dado_valido at cycle 3 after the press; a single-cycle glitch is accepted.
